// File: rtl/mmul_parallel_sink_agen.sv
// Write-side address generator for the matmul engine: drains a result stream into TCDM
// through a one-word buffer, walking a strided line pattern of byte addresses.
module mmul_parallel_sink_agen #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  req_start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  trans_size_i,
    input  logic [CNT_WIDTH-1:0]  line_length_i,
    input  logic [ADDR_WIDTH-1:0] line_stride_i,
    output logic                  ready_start_o,
    output logic                  done_o,
    input  logic                  stream_valid_i,
    input  logic [DATA_WIDTH-1:0] stream_data_i,
    output logic                  stream_ready_o,
    output logic                  tcdm_req_o,
    output logic [ADDR_WIDTH-1:0] tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [3:0]            tcdm_be_o,
    output logic [DATA_WIDTH-1:0] tcdm_data_o,
    input  logic                  tcdm_gnt_i
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                r_state;
    logic [CNT_WIDTH-1:0]  r_trans_size;
    logic [CNT_WIDTH-1:0]  r_line_length;
    logic [ADDR_WIDTH-1:0] r_line_stride;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic [CNT_WIDTH-1:0]  r_line_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_line_base;
    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_buf_data;

    logic                  w_gnt;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_line_end;
    logic [CNT_WIDTH-1:0]  w_line_cnt_inc;

    assign w_gnt          = r_buf_full & tcdm_gnt_i;
    assign w_last         = w_gnt & (r_word_cnt == (r_trans_size - CNT_WIDTH'(1)));
    assign w_line_cnt_inc = r_line_cnt + CNT_WIDTH'(1);
    // A zero line length never wraps: the whole transfer is one line.
    assign w_line_end     = (r_line_length != '0) && (w_line_cnt_inc == r_line_length);

    // The last grant closes the transfer, so no beat may slip into the buffer behind it.
    assign stream_ready_o = (r_state == StRun) & (~r_buf_full | tcdm_gnt_i) & ~w_last;
    assign w_accept       = stream_valid_i & stream_ready_o;

    assign ready_start_o  = (r_state == StIdle);
    assign done_o         = (r_state == StDone);
    assign tcdm_req_o     = r_buf_full;
    assign tcdm_wen_o     = ~r_buf_full;
    assign tcdm_be_o      = r_buf_full ? 4'hF : 4'h0;
    assign tcdm_add_o     = r_addr;
    assign tcdm_data_o    = r_buf_data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state       <= StIdle;
            r_trans_size  <= '0;
            r_line_length <= '0;
            r_line_stride <= '0;
            r_word_cnt    <= '0;
            r_line_cnt    <= '0;
            r_addr        <= '0;
            r_line_base   <= '0;
            r_buf_full    <= 1'b0;
            r_buf_data    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_start_i) begin
                        r_trans_size  <= trans_size_i;
                        r_line_length <= line_length_i;
                        r_line_stride <= line_stride_i;
                        r_word_cnt    <= '0;
                        r_line_cnt    <= '0;
                        r_addr        <= base_addr_i;
                        r_line_base   <= base_addr_i;
                        r_state       <= (trans_size_i == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (w_gnt) begin
                        r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
                        if (w_line_end) begin
                            r_line_cnt <= '0;
                            if (r_line_stride == '0) begin
                                r_addr <= r_addr + ADDR_WIDTH'(4);
                            end else begin
                                r_line_base <= r_line_base + r_line_stride;
                                r_addr      <= r_line_base + r_line_stride;
                            end
                        end else begin
                            r_line_cnt <= w_line_cnt_inc;
                            r_addr     <= r_addr + ADDR_WIDTH'(4);
                        end
                        if (w_last) begin
                            r_state <= StDone;
                        end
                    end
                    if (w_accept) begin
                        r_buf_full <= 1'b1;
                        r_buf_data <= stream_data_i;
                    end else if (w_gnt) begin
                        r_buf_full <= 1'b0;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmul_parallel_sink_agen.sv
// Bench for mmul_parallel_sink_agen: directed transfers checked against an address/data
// model computed from line geometry, plus literal address pins.
module tb_mmul_parallel_sink_agen;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          req_start_i;
    logic [AW-1:0] base_addr_i;
    logic [CW-1:0] trans_size_i;
    logic [CW-1:0] line_length_i;
    logic [AW-1:0] line_stride_i;
    logic          ready_start_o;
    logic          done_o;
    logic          stream_valid_i;
    logic [DW-1:0] stream_data_i;
    logic          stream_ready_o;
    logic          tcdm_req_o;
    logic [AW-1:0] tcdm_add_o;
    logic          tcdm_wen_o;
    logic [3:0]    tcdm_be_o;
    logic [DW-1:0] tcdm_data_o;
    logic          tcdm_gnt_i;

    always #5 clk = ~clk;

    mmul_parallel_sink_agen #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .req_start_i   (req_start_i),
        .base_addr_i   (base_addr_i),
        .trans_size_i  (trans_size_i),
        .line_length_i (line_length_i),
        .line_stride_i (line_stride_i),
        .ready_start_o (ready_start_o),
        .done_o        (done_o),
        .stream_valid_i(stream_valid_i),
        .stream_data_i (stream_data_i),
        .stream_ready_o(stream_ready_o),
        .tcdm_req_o    (tcdm_req_o),
        .tcdm_add_o    (tcdm_add_o),
        .tcdm_wen_o    (tcdm_wen_o),
        .tcdm_be_o     (tcdm_be_o),
        .tcdm_data_o   (tcdm_data_o),
        .tcdm_gnt_i    (tcdm_gnt_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model configuration of the transfer in flight.
    logic [31:0] m_base = '0;
    logic [31:0] m_stride = '0;
    int          m_trans = 0;
    int          m_len = 0;
    logic [7:0]  m_tag = '0;

    int          cyc = 0;
    int          g_cnt = 0;
    int          s_idx = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          stall_seen = 0;
    int          first_acc = -1;
    int          first_req = -1;
    int          last_gnt_cyc = 0;
    bit          acc_q = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_add = '0;
    logic [31:0] prev_data = '0;
    logic [31:0] obs_addr [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        logic [31:0] kk;
        kk = k;
        return {m_tag, 8'h5A, kk[15:0]};
    endfunction

    // Word k sits in line k/len at offset k%len; a zero length or zero stride is one flat run.
    function automatic logic [31:0] exp_addr(input int k);
        if (m_len == 0 || m_stride == 0) return m_base + 32'(4 * k);
        return m_base + 32'(k / m_len) * m_stride + 32'(4 * (k % m_len));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (prev_stall) begin
                chk("stall_req_held", {31'd0, tcdm_req_o}, 32'd1);
                chk("stall_add_stable", tcdm_add_o, prev_add);
                chk("stall_data_stable", tcdm_data_o, prev_data);
            end
            if (tcdm_req_o && !tcdm_gnt_i) begin
                chk("stall_stream_ready", {31'd0, stream_ready_o}, 32'd0);
                stall_seen++;
            end
            if (tcdm_req_o) begin
                chk("wen_write", {31'd0, tcdm_wen_o}, 32'd0);
                chk("be_full", {28'd0, tcdm_be_o}, 32'h0000_000F);
                if (first_req < 0) first_req = cyc;
            end
            if (tcdm_req_o && tcdm_gnt_i) begin
                if (g_cnt < m_trans && g_cnt < 64) begin
                    chk("grant_addr", tcdm_add_o, exp_addr(g_cnt));
                    chk("grant_data", tcdm_data_o, pat(g_cnt));
                    obs_addr[g_cnt] = tcdm_add_o;
                end else begin
                    chk("grant_count_in_range", g_cnt, m_trans - 1);
                end
                last_gnt_cyc = cyc;
                g_cnt++;
            end
            if (stream_valid_i && stream_ready_o && first_acc < 0) first_acc = cyc;
            acc_q = stream_valid_i & stream_ready_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = tcdm_req_o & ~tcdm_gnt_i;
            prev_add   = tcdm_add_o;
            prev_data  = tcdm_data_o;
        end else begin
            prev_stall = 1'b0;
            acc_q      = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (acc_q) s_idx++;
        stream_data_i = pat(s_idx);
    endtask

    task automatic arm(input logic [31:0] base, input int trans, input int len,
                       input logic [31:0] stride, input logic [7:0] tag);
        m_base = base; m_trans = trans; m_len = len; m_stride = stride; m_tag = tag;
        g_cnt = 0; s_idx = 0; done_cnt = 0; stall_seen = 0; first_acc = -1; first_req = -1;
        stream_data_i  = pat(0);
        stream_valid_i = 1'b1;
        tcdm_gnt_i     = 1'b1;
        chk("ready_start_idle", {31'd0, ready_start_o}, 32'd1);
        base_addr_i   = base;
        trans_size_i  = CW'(trans);
        line_length_i = CW'(len);
        line_stride_i = stride;
        req_start_i   = 1'b1;
    endtask

    task automatic run_xfer(input logic [31:0] base, input int trans, input int len,
                            input logic [31:0] stride, input int stall_word, input int stall_n,
                            input int rs_cyc, input logic [7:0] tag);
        int stall_left;
        int start_cyc;
        stall_left = stall_n;
        arm(base, trans, len, stride, tag);
        start_cyc = cyc;
        tick();
        req_start_i = 1'b0;
        for (int c = 0; c < 200 && done_cnt == 0; c++) begin
            if (c == rs_cyc) begin
                chk("ready_start_in_run", {31'd0, ready_start_o}, 32'd0);
                req_start_i   = 1'b1;
                base_addr_i   = 32'h0000_9000;
                trans_size_i  = CW'(2);
                line_length_i = CW'(1);
                line_stride_i = 32'h10;
            end else begin
                req_start_i = 1'b0;
            end
            if (tcdm_req_o && g_cnt == stall_word && stall_left > 0) begin
                tcdm_gnt_i = 1'b0;
                stall_left--;
            end else begin
                tcdm_gnt_i = 1'b1;
            end
            tick();
        end
        req_start_i = 1'b0;
        chk("done_seen", done_cnt, 1);
        tick();
        tick();
        chk("done_once", done_cnt, 1);
        chk("grant_total", g_cnt, trans);
        chk("beat_total", s_idx, trans);
        chk("stall_cycles", stall_seen, stall_n);
        chk("ready_start_after", {31'd0, ready_start_o}, 32'd1);
        if (trans > 0) begin
            chk("first_req_latency", first_req, first_acc + 1);
            chk("done_after_last_gnt", done_cyc, last_gnt_cyc + 1);
            chk("done_time", done_cyc, start_cyc + 2 + trans + stall_n);
        end else begin
            chk("zero_no_req", first_req, -1);
            chk("zero_done_time", done_cyc, start_cyc + 1);
        end
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; req_start_i = 1'b0;
        base_addr_i = '0; trans_size_i = '0; line_length_i = '0; line_stride_i = '0;
        stream_valid_i = 1'b0; stream_data_i = '0; tcdm_gnt_i = 1'b0;
        for (int i = 0; i < 64; i++) obs_addr[i] = '0;
        tick();
        tick();
        chk("rst_ready_start", {31'd0, ready_start_o}, 32'd1);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_stream_ready", {31'd0, stream_ready_o}, 32'd0);
        chk("rst_req", {31'd0, tcdm_req_o}, 32'd0);
        chk("rst_add", tcdm_add_o, 32'd0);
        chk("rst_data", tcdm_data_o, 32'd0);
        chk("rst_wen", {31'd0, tcdm_wen_o}, 32'd1);
        chk("rst_be", {28'd0, tcdm_be_o}, 32'd0);
        rst_ni = 1'b1;
        tick();

        run_xfer(32'h0000_1000, 4, 4, 32'h0, -1, 0, -1, 8'h11);
        chk("pin_contig_0", obs_addr[0], 32'h0000_1000);
        chk("pin_contig_3", obs_addr[3], 32'h0000_100C);

        run_xfer(32'h0000_2000, 6, 2, 32'h100, -1, 0, -1, 8'h22);
        chk("pin_stride_2", obs_addr[2], 32'h0000_2100);
        chk("pin_stride_5", obs_addr[5], 32'h0000_2204);

        run_xfer(32'h0000_3000, 5, 0, 32'h40, 1, 3, -1, 8'h33);
        chk("pin_nowrap_4", obs_addr[4], 32'h0000_3010);

        run_xfer(32'h0000_0000, 0, 4, 32'h0, -1, 0, -1, 8'h44);

        // Clear with word 2 outstanding.
        arm(32'h0000_5000, 8, 8, 32'h0, 8'h55);
        tick();
        req_start_i = 1'b0;
        for (int c = 0; c < 50 && g_cnt < 2; c++) tick();
        chk("clr_req_outstanding", {31'd0, tcdm_req_o}, 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_ready_start", {31'd0, ready_start_o}, 32'd1);
        chk("clr_req", {31'd0, tcdm_req_o}, 32'd0);
        chk("clr_add", tcdm_add_o, 32'd0);
        for (int c = 0; c < 5; c++) tick();
        chk("clr_no_done", done_cnt, 0);
        chk("clr_still_idle_req", {31'd0, tcdm_req_o}, 32'd0);

        run_xfer(32'h0000_6000, 3, 2, 32'h0, -1, 0, -1, 8'h56);
        chk("pin_after_clr_2", obs_addr[2], 32'h0000_6008);

        run_xfer(32'h0000_4000, 6, 3, 32'h20, -1, 0, 2, 8'h66);
        chk("pin_ignore_start_3", obs_addr[3], 32'h0000_4020);

        run_xfer(32'hFFFF_FFF8, 4, 0, 32'h0, -1, 0, -1, 8'h77);
        chk("pin_wrap_2", obs_addr[2], 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
